// File: rtl/aes_encrypt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_encrypt                                                  |
// | Description : Iterative AES block encryptor. The key schedule is expanded  |
// |               one word per cycle, then one round is applied per cycle.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_encrypt #(
    parameter int LEN_KEY   = 128,
    parameter int NUM_ROUND = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       data_in,
    input  logic [LEN_KEY-1:0] key,
    output logic [127:0]       data_out,
    output logic               busy,
    output logic               done
);
    localparam int c_NK = LEN_KEY / 32;
    localparam int c_NW = 4 * (NUM_ROUND + 1);
    localparam int c_IW = $clog2(c_NW + 1);
    localparam logic [c_IW-1:0] c_IDX_FIRST = c_IW'(c_NK);
    localparam logic [c_IW-1:0] c_IDX_END   = c_IW'(c_NW);
    localparam logic [3:0]      c_NK_LAST   = 4'(c_NK - 1);
    localparam logic [3:0]      c_NR        = 4'(NUM_ROUND);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EXPAND = 2'd1;
    localparam logic [1:0] c_ST_ROUND  = 2'd2;

    generate
        if (!(LEN_KEY == 128 || LEN_KEY == 192 || LEN_KEY == 256)) begin : g_bad_len_key
            $error("aes_encrypt: LEN_KEY must be 128, 192 or 256");
        end
        if (NUM_ROUND != LEN_KEY / 32 + 6) begin : g_bad_num_round
            $error("aes_encrypt: NUM_ROUND must equal LEN_KEY/32+6");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [1:0]      r_fsm;
    logic [1:0]      w_fsm_next;
    logic [127:0]    r_blk;
    logic [31:0]     r_w [0:c_NW-1];
    logic [c_IW-1:0] r_idx;
    logic [3:0]      r_kcnt;
    logic [7:0]      r_rcon;
    logic [3:0]      r_round;

    logic [7:0]      w_sb [0:15];
    logic [127:0]    w_shift;
    logic [127:0]    w_mix;
    logic [127:0]    w_rkey;
    logic [127:0]    w_round;
    logic [c_IW-1:0] w_rk_base;
    logic [31:0]     w_prev;
    logic [31:0]     w_back;
    logic [31:0]     w_sub;
    logic [31:0]     w_temp;
    logic [31:0]     w_new;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_state_sbox
            assign w_sb[gi] = sbox(r_blk[127-8*gi -: 8]);
        end

        // Column gc after ShiftRows: row r comes from column (gc+r)%4.
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_sb[4*gi];
            assign w_a1 = w_sb[4*((gi+1)%4)+1];
            assign w_a2 = w_sb[4*((gi+2)%4)+2];
            assign w_a3 = w_sb[4*((gi+3)%4)+3];
            assign w_shift[127-32*gi -: 32] = {w_a0, w_a1, w_a2, w_a3};
            assign w_mix[127-32*gi -: 32] = {
                xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
                w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
                xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
            };
        end

        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign w_sub[31-8*gi -: 8] = sbox(w_prev[31-8*gi -: 8]);
        end
    endgenerate

    assign w_rk_base = c_IW'({r_round, 2'b00});
    assign w_rkey    = {r_w[w_rk_base], r_w[w_rk_base + c_IW'(1)],
                        r_w[w_rk_base + c_IW'(2)], r_w[w_rk_base + c_IW'(3)]};
    assign w_round   = ((r_round == c_NR) ? w_shift : w_mix) ^ w_rkey;

    assign w_prev = r_w[r_idx - c_IW'(1)];
    assign w_back = r_w[r_idx - c_IW'(c_NK)];

    // SubWord commutes with RotWord, so the rotation is applied after substitution.
    always_comb begin
        w_temp = w_prev;
        if (r_kcnt == 4'd0) begin
            w_temp = {w_sub[23:0], w_sub[31:24]} ^ {r_rcon, 24'h000000};
        end else if (c_NK == 8 && r_kcnt == 4'd4) begin
            w_temp = w_sub;
        end
    end
    assign w_new = w_back ^ w_temp;

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= c_ST_IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_ST_IDLE:   if (start) w_fsm_next = c_ST_EXPAND;
            c_ST_EXPAND: if (r_idx == c_IDX_END) w_fsm_next = c_ST_ROUND;
            c_ST_ROUND:  if (r_round == c_NR) w_fsm_next = c_ST_IDLE;
            default:     w_fsm_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk    <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_idx    <= '0;
            r_kcnt   <= '0;
            r_rcon   <= 8'h01;
            r_round  <= '0;
            for (int k = 0; k < c_NW; k++) r_w[k] <= '0;
        end else begin
            done <= 1'b0;
            case (r_fsm)
                c_ST_IDLE: begin
                    if (start) begin
                        r_blk <= data_in;
                        for (int k = 0; k < c_NK; k++) r_w[k] <= key[LEN_KEY-1-32*k -: 32];
                        r_idx  <= c_IDX_FIRST;
                        r_kcnt <= '0;
                        r_rcon <= 8'h01;
                        busy   <= 1'b1;
                    end
                end
                c_ST_EXPAND: begin
                    if (r_idx == c_IDX_END) begin
                        r_blk   <= r_blk ^ {r_w[0], r_w[1], r_w[2], r_w[3]};
                        r_round <= 4'd1;
                    end else begin
                        r_w[r_idx] <= w_new;
                        r_idx      <= r_idx + c_IW'(1);
                        if (r_kcnt == 4'd0) r_rcon <= xtime(r_rcon);
                        r_kcnt <= (r_kcnt == c_NK_LAST) ? 4'd0 : r_kcnt + 4'd1;
                    end
                end
                c_ST_ROUND: begin
                    r_blk   <= w_round;
                    r_round <= r_round + 4'd1;
                    if (r_round == c_NR) begin
                        data_out <= w_round;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_encrypt                                               |
// | Description : Self-checking bench for aes_encrypt in 128/192/256 variants. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aes_encrypt;
    logic         clk;
    logic         rst;
    logic         start128, start192, start256;
    logic [127:0] din;
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;
    logic [127:0] dout128, dout192, dout256;
    logic         busy128, busy192, busy256;
    logic         done128, done192, done256;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_tab [0:255];

    aes_encrypt #(.LEN_KEY(128), .NUM_ROUND(10)) u_d128 (
        .clk(clk), .rst(rst), .start(start128), .data_in(din), .key(k128),
        .data_out(dout128), .busy(busy128), .done(done128));
    aes_encrypt #(.LEN_KEY(192), .NUM_ROUND(12)) u_d192 (
        .clk(clk), .rst(rst), .start(start192), .data_in(din), .key(k192),
        .data_out(dout192), .busy(busy192), .done(done192));
    aes_encrypt #(.LEN_KEY(256), .NUM_ROUND(14)) u_d256 (
        .clk(clk), .rst(rst), .start(start256), .data_in(din), .key(k256),
        .data_out(dout256), .busy(busy256), .done(done256));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Walk the field with generator 3 and its inverse in lockstep to fill the table.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb_tab[0] = 8'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sb_tab[v[31:24]], sb_tab[v[23:16]], sb_tab[v[15:8]], sb_tab[v[7:0]]};
    endfunction

    // Reference cipher; the key is left-aligned in 256 bits.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int nk);
        int nr;
        logic [31:0] w [0:59];
        logic [7:0]  s [0:15];
        logic [7:0]  t [0:15];
        logic [7:0]  rc;
        logic [31:0] tmp;
        logic [127:0] res;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int n = 0; n < 16; n++) s[n] = sb_tab[s[n]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    if (r == nr) s[4*c+rw] = t[4*c+rw];
                    else s[4*c+rw] = gmul(t[4*c+rw], 8'h02) ^ gmul(t[4*c+(rw+1)%4], 8'h03)
                                     ^ t[4*c+(rw+2)%4] ^ t[4*c+(rw+3)%4];
            for (int n = 0; n < 16; n++) s[n] ^= w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sel_done(input int sel);
        case (sel)
            0: return done128;
            1: return done192;
            default: return done256;
        endcase
    endfunction

    function automatic logic sel_busy(input int sel);
        case (sel)
            0: return busy128;
            1: return busy192;
            default: return busy256;
        endcase
    endfunction

    function automatic logic [127:0] sel_dout(input int sel);
        case (sel)
            0: return dout128;
            1: return dout192;
            default: return dout256;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start128 = v;
            1: start192 = v;
            default: start256 = v;
        endcase
    endtask

    task automatic load(input logic [127:0] pt, input logic [255:0] k);
        din  = pt;
        k128 = k[255:128];
        k192 = k[255:64];
        k256 = k;
    endtask

    // Returns with time just after the start-sampling edge.
    task automatic pulse_start(input int sel, input logic [127:0] pt, input logic [255:0] k);
        @(negedge clk);
        load(pt, k);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    task automatic wait_done(input int sel, output int cnt);
        cnt = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (sel_done(sel)) begin
                cnt = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input int sel, input logic [127:0] pt,
                           input logic [255:0] k, input logic [127:0] exp, input int lat);
        int cnt;
        pulse_start(sel, pt, k);
        check({name, " busy"}, 128'(sel_busy(sel)), 128'd1);
        wait_done(sel, cnt);
        check({name, " latency"}, 128'(cnt), 128'(lat));
        check({name, " data_out"}, sel_dout(sel), exp);
        check({name, " busy at done"}, 128'(sel_busy(sel)), 128'd0);
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, 128'(sel_done(sel)), 128'd0);
    endtask

    typedef struct {
        string        name;
        int           sel;
        logic [127:0] pt;
        logic [255:0] k;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY2 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        vec_t vecs [0:3];
        int   cnt, ndone, first;
        logic [127:0] res;
        logic [127:0] pt;
        logic [255:0] k;
        int   nk;

        build_sbox();
        vecs[0] = '{"fips128", 0, PT1, KEY1, CT1, 51};
        vecs[1] = '{"std128", 0, PT2, KEY2, CT2, 51};
        vecs[2] = '{"std192", 1, PT2, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 59};
        vecs[3] = '{"std256", 2, PT2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 67};

        rst = 1'b1;
        start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        load(128'h0, 256'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("reset data_out", sel_dout(s), 128'h0);
            check("reset busy", 128'(sel_busy(s)), 128'd0);
            check("reset done", 128'(sel_done(s)), 128'd0);
        end

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i].name, vecs[i].sel, vecs[i].pt, vecs[i].k, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 12; i++) begin
            int s;
            s  = (i < 6) ? 0 : (i < 9) ? 1 : 2;
            nk = 4 + 2 * s;
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (nk == 4) k[127:0] = '0;
            if (nk == 6) k[63:0] = '0;
            run_vec("random", s, pt, k, aes_ref(pt, k, nk), 5 * (nk + 6) + 5 - nk);
        end

        // Second start mid-run must be ignored.
        pulse_start(0, PT1, KEY1);
        ndone = 0;
        first = -1;
        res   = '0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                load(PT2, KEY2);
                start128 = 1'b1;
            end
            @(posedge clk);
            #1;
            if (c == 10) start128 = 1'b0;
            if (done128) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    res   = dout128;
                end
            end
        end
        check("ignored start latency", 128'(first), 128'd51);
        check("ignored start result", res, CT1);
        check("ignored start done count", 128'(ndone), 128'd1);
        check("ignored start data_out held", dout128, CT1);

        // Reset in the middle of a run aborts it.
        pulse_start(0, PT2, KEY2);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort data_out", dout128, 128'h0);
        check("abort busy", 128'(busy128), 128'd0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (done128) ndone++;
        end
        check("abort no done", 128'(ndone), 128'd0);
        run_vec("after abort", 0, PT2, KEY2, CT2, 51);

        // Back-to-back: start during the done cycle.
        pulse_start(0, PT1, KEY1);
        wait_done(0, cnt);
        check("b2b first latency", 128'(cnt), 128'd51);
        check("b2b first data_out", dout128, CT1);
        load(PT2, KEY2);
        start128 = 1'b1;
        @(posedge clk);
        #1;
        start128 = 1'b0;
        check("b2b busy", 128'(busy128), 128'd1);
        wait_done(0, cnt);
        check("b2b second latency", 128'(cnt), 128'd51);
        check("b2b second data_out", dout128, CT2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
